// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and its consumers
// (pixel generator and connector).
interface vga_timing_gen_if;
   logic       en;
   logic       pix_tick;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       valid;
   logic       hsync;
   logic       vsync;
   logic       frame_done;
   logic [7:0] frame_cnt;

   modport master (
      input  en,
      output pix_tick, h_cnt, v_cnt, valid, hsync, vsync, frame_done, frame_cnt
   );

   modport slave (
      output en,
      input  pix_tick, h_cnt, v_cnt, valid, hsync, vsync, frame_done, frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, idle/run control and h/v counters with
// registered sync, visible-area and frame-wrap outputs.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic               clk,
   input  logic               rst_n,
   vga_timing_gen_if.master   tim_io
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [3:0] DivMax  = 4'(CLK_DIV - 1);
   localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
   localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HVis    = 10'(H_VISIBLE);
   localparam logic [9:0] VVis    = 10'(V_VISIBLE);
   localparam logic [9:0] HsStart = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HsEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VsStart = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VsEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic {StIdle, StRun} state_e;

   state_e     state_q, state_d;
   logic [3:0] div_q, div_d;
   logic       pix_tick_q, pix_tick_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       valid_q, valid_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       frame_done_q;
   logic [7:0] frame_cnt_q;
   logic       run_d;
   logic       wrap;

   always_comb begin
      div_d      = (div_q == DivMax) ? 4'd0 : div_q + 4'd1;
      // The tick is registered, so counters move on the edge that raises it.
      pix_tick_d = (div_d == DivMax);
      wrap       = (state_q == StRun) && (h_q == HLast) && (v_q == VLast);
      h_d        = 10'd0;
      v_d        = 10'd0;
      run_d      = 1'b0;
      unique case (state_q)
         StIdle: run_d = tim_io.en;
         StRun: begin
            // en only matters at the frame wrap; mid-frame drops are ignored.
            run_d = wrap ? tim_io.en : 1'b1;
            if (h_q != HLast) begin
               h_d = h_q + 10'd1;
               v_d = v_q;
            end else if (v_q != VLast) begin
               v_d = v_q + 10'd1;
            end
         end
      endcase
      state_d = run_d ? StRun : StIdle;
      // Flags decode the updated position so they always match h_cnt/v_cnt.
      valid_d = run_d && (h_d < HVis) && (v_d < VVis);
      hsync_d = !(run_d && (h_d >= HsStart) && (h_d < HsEnd));
      vsync_d = !(run_d && (v_d >= VsStart) && (v_d < VsEnd));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         div_q        <= 4'd0;
         pix_tick_q   <= 1'b0;
         h_q          <= 10'd0;
         v_q          <= 10'd0;
         valid_q      <= 1'b0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 8'd0;
      end else begin
         div_q        <= div_d;
         pix_tick_q   <= pix_tick_d;
         frame_done_q <= 1'b0;
         if (pix_tick_d) begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            if (wrap) begin
               frame_done_q <= 1'b1;
               frame_cnt_q  <= frame_cnt_q + 8'd1;
            end
         end
      end
   end

   assign tim_io.pix_tick   = pix_tick_q;
   assign tim_io.h_cnt      = h_q;
   assign tim_io.v_cnt      = v_q;
   assign tim_io.valid      = valid_q;
   assign tim_io.hsync      = hsync_q;
   assign tim_io.vsync      = vsync_q;
   assign tim_io.frame_done = frame_done_q;
   assign tim_io.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster; a linear-position reference
// model predicts every output in every clock.
module tb_vga_timing_gen;

   localparam int unsigned D  = 3;
   localparam int unsigned HV = 4, HF = 1, HS = 2, HB = 1;
   localparam int unsigned VV = 3, VF = 1, VS = 2, VB = 1;
   localparam int unsigned HT = HV + HF + HS + HB;
   localparam int unsigned VT = VV + VF + VS + VB;
   localparam int unsigned FT = HT * VT;
   localparam logic [32:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   vga_timing_gen_if tim ();

   vga_timing_gen #(
      .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .tim_io (tim)
   );

   always #5 clk = ~clk;

   // Reference model: clocks since reset, run flag, linear raster position.
   int unsigned m_n, m_pos;
   bit          m_run, m_fd;
   logic [7:0]  m_fc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n <= 0; m_pos <= 0; m_run <= 0; m_fd <= 0; m_fc <= 8'd0;
      end else begin
         m_n  <= m_n + 1;
         m_fd <= 0;
         if ((m_n + 1) % D == D - 1) begin
            if (!m_run) begin
               if (tim.en) begin m_run <= 1; m_pos <= 0; end
            end else if (m_pos == FT - 1) begin
               m_pos <= 0; m_fd <= 1; m_fc <= m_fc + 8'd1; m_run <= tim.en;
            end else begin
               m_pos <= m_pos + 1;
            end
         end
      end
   end

   int unsigned mh, mv;
   logic [32:0] exp_vec;
   wire  [32:0] dut_vec = {tim.pix_tick, tim.h_cnt, tim.v_cnt, tim.valid, tim.hsync,
                           tim.vsync, tim.frame_done, tim.frame_cnt};

   always_comb begin
      mh = m_run ? m_pos % HT : 0;
      mv = m_run ? m_pos / HT : 0;
      exp_vec = {(m_n % D) == D - 1, 10'(mh), 10'(mv), m_run && mh < HV && mv < VV,
                 !(m_run && mh >= HV + HF && mh < HV + HF + HS),
                 !(m_run && mv >= VV + VF && mv < VV + VF + VS), m_fd, m_fc};
   end

   task automatic test_reset();
      rst_n = 1'b0;
      tim.en = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec, RST_VEC);
         end
      end
   endtask

   task automatic test_first_ticks();
      tim.en = 1'b1;
      rst_n  = 1'b1;
      for (int k = 1; k <= 3 * D + 1; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL start_model k=%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
         if (k == D - 1) begin
            checks++;
            if ({tim.pix_tick, tim.h_cnt, tim.v_cnt, tim.valid, tim.hsync} !==
                {1'b1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
               errors++;
               $display("FAIL first_tick: got pix=%b h=%0d v=%0d valid=%b hs=%b expected 1 0 0 1 1",
                        tim.pix_tick, tim.h_cnt, tim.v_cnt, tim.valid, tim.hsync);
            end
         end
         if (k == 2 * D - 1) begin
            checks++;
            if (tim.h_cnt !== 10'd1) begin
               errors++;
               $display("FAIL second_tick_h: got %0d expected 1", tim.h_cnt);
            end
         end
      end
   endtask

   task automatic test_line();
      int hs_low = 0, vis = 0;
      logic [9:0] ph, pv;
      ph = tim.h_cnt; pv = tim.v_cnt;
      for (int k = 0; k < HT * D; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL line_model: got %h expected %h", dut_vec, exp_vec);
         end
         if (tim.pix_tick) begin
            if (!tim.hsync) hs_low++;
            if (tim.valid) vis++;
            if (ph == 10'(HT - 1)) begin
               checks++;
               if (tim.h_cnt !== 10'd0 || tim.v_cnt !== pv + 10'd1) begin
                  errors++;
                  $display("FAIL line_wrap: got h=%0d v=%0d expected h=0 v=%0d",
                           tim.h_cnt, tim.v_cnt, pv + 10'd1);
               end
            end
            ph = tim.h_cnt; pv = tim.v_cnt;
         end
      end
      checks++;
      if (hs_low != HS) begin
         errors++;
         $display("FAIL hsync_width: got %0d expected %0d", hs_low, HS);
      end
      checks++;
      if (vis != HV) begin
         errors++;
         $display("FAIL valid_width: got %0d expected %0d", vis, HV);
      end
   endtask

   task automatic test_frame();
      int vs_low = 0, fd = 0, bad_vis = 0;
      for (int k = 0; k < FT * D; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL frame_model: got %h expected %h", dut_vec, exp_vec);
         end
         if (tim.pix_tick && !tim.vsync) vs_low++;
         if (tim.valid && tim.v_cnt >= 10'(VV)) bad_vis++;
         if (tim.frame_done) begin
            fd++;
            checks++;
            if (tim.h_cnt !== 10'd0 || tim.v_cnt !== 10'd0) begin
               errors++;
               $display("FAIL frame_done_pos: got h=%0d v=%0d expected 0 0", tim.h_cnt, tim.v_cnt);
            end
         end
      end
      checks++;
      if (vs_low != VS * HT) begin
         errors++;
         $display("FAIL vsync_width: got %0d expected %0d", vs_low, VS * HT);
      end
      checks++;
      if (bad_vis != 0) begin
         errors++;
         $display("FAIL valid_below_visible: got %0d expected 0", bad_vis);
      end
      checks++;
      if (fd != 1 || tim.frame_cnt !== 8'd1) begin
         errors++;
         $display("FAIL frame_count: got pulses=%0d cnt=%0d expected 1 1", fd, tim.frame_cnt);
      end
   endtask

   task automatic test_en_drop();
      bit found = 0;
      int fd = 0;
      int hold;
      for (int k = 0; k < 2 * FT * D && !found; k++) begin
         @(negedge clk);
         if (tim.v_cnt == 10'd2) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_v2: got timeout expected v_cnt=2");
      end
      tim.en = 1'b0;
      found = 0;
      for (int k = 0; k < FT * D + D && !found; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL drop_model: got %h expected %h", dut_vec, exp_vec);
         end
         if (tim.frame_done) found = 1;
      end
      checks++;
      if (!found || tim.frame_cnt !== 8'd2) begin
         errors++;
         $display("FAIL drop_wrap: got done=%0d cnt=%0d expected 1 2", found, tim.frame_cnt);
      end
      hold = $urandom_range(5, 40);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         checks++;
         if ({tim.h_cnt, tim.v_cnt, tim.valid, tim.hsync, tim.vsync, tim.frame_done} !==
             {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0} || dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", dut_vec, exp_vec);
         end
      end
      tim.en = 1'b1;
      found = 0;
      for (int k = 0; k < D + 1 && !found; k++) begin
         @(negedge clk);
         if (tim.pix_tick) found = 1;
      end
      checks++;
      if (!found || {tim.h_cnt, tim.v_cnt, tim.valid, tim.frame_done, tim.frame_cnt} !==
          {10'd0, 10'd0, 1'b1, 1'b0, 8'd2}) begin
         errors++;
         $display("FAIL restart: got tick=%0d h=%0d v=%0d valid=%b fd=%b cnt=%0d expected 1 0 0 1 0 2",
                  found, tim.h_cnt, tim.v_cnt, tim.valid, tim.frame_done, tim.frame_cnt);
      end
   endtask

   task automatic test_async_reset();
      bit found = 0;
      for (int k = 0; k < 2 * FT * D && !found; k++) begin
         @(negedge clk);
         if (tim.h_cnt == 10'(HV + HF) && tim.v_cnt == 10'd1) found = 1;
      end
      checks++;
      if (!found || tim.hsync !== 1'b0) begin
         errors++;
         $display("FAIL wait_hsync_low: got found=%0d hs=%b expected 1 0", found, tim.hsync);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec !== RST_VEC) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", dut_vec, RST_VEC);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int left = 0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if (left == 0) begin
            tim.en = 1'($urandom_range(0, 1));
            left = $urandom_range(1, 3 * FT);
         end
         left--;
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL random_model k=%0d: got %h expected %h", k, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_wrap256();
      int fd = 0;
      bit saw_wrap = 0;
      logic [7:0] pc;
      rst_n = 1'b0;
      tim.en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      pc = tim.frame_cnt;
      for (int k = 0; k < (256 * FT + 1) * D + 1; k++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL wrap_model: got %h expected %h", dut_vec, exp_vec);
         end
         if (tim.frame_done) fd++;
         if (pc == 8'd255 && tim.frame_cnt == 8'd0) saw_wrap = 1;
         pc = tim.frame_cnt;
      end
      checks++;
      if (fd != 256 || !saw_wrap || tim.frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL frame_cnt_wrap: got pulses=%0d wrap=%0d cnt=%0d expected 256 1 0",
                  fd, saw_wrap, tim.frame_cnt);
      end
   endtask

   initial begin
      tim.en = 1'b0;
      test_reset();
      test_first_ticks();
      test_line();
      test_frame();
      test_en_drop();
      test_async_reset();
      test_random();
      test_wrap256();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz board clock.
- Produces the h_cnt, v_cnt and valid inputs consumed by the downstream background/pixel generator, plus hsync and vsync for the connector.
- Includes a pixel-rate divider, a run/idle control FSM, and a frame counter that animation logic can use.

Parameters:
- CLK_DIV, 4, board clocks per pixel (pixel rate 25 MHz); legal range 2..15.
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  in  1  board clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request; sampled as described under Behaviour.
- pix_tick  out  1  one-clk pulse marking each pixel period.
- h_cnt  out  10  horizontal position, 0..H_TOTAL-1.
- v_cnt  out  10  vertical position, 0..V_TOTAL-1.
- valid  out  1  high while (h_cnt, v_cnt) is in the visible area.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- frame_done  out  1  one-clk pulse at each frame wrap.
- frame_cnt  out  8  completed-frame count, wraps 255->0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Reset values (rst_n=0, asynchronous): div_cnt=0, pix_tick=0, h_cnt=0, v_cnt=0, valid=0, hsync=1, vsync=1, frame_done=0, frame_cnt=0, FSM=IDLE.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick=1 exactly in the clk cycle where div_cnt==CLK_DIV-1. The divider runs regardless of FSM state.
- All outputs are registered. Counters and flags update only in the cycle where pix_tick=1, so each (h_cnt, v_cnt, valid, hsync, vsync) tuple is stable for CLK_DIV clks.
- Flag decode applies to the updated counter values, so flags are always consistent with the h_cnt/v_cnt presented alongside them:
  - valid = (h<H_VISIBLE)&&(v<V_VISIBLE)
  - hsync = 0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vsync = 0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491)
- FSM IDLE:
  - Counters held at 0; valid=0, hsync=1, vsync=1.
  - On pix_tick with en=1: move to RUN and load flags for (0,0), so valid=1, with h_cnt=0, v_cnt=0.
  - On pix_tick with en=0: stay in IDLE.
- FSM RUN, on each pix_tick:
  - If h<H_TOTAL-1: h+1.
  - Otherwise h=0, and v+1, or v=0 if v==V_TOTAL-1.
- Frame wrap is the pix_tick taking (H_TOTAL-1, V_TOTAL-1) to (0,0). On that tick:
  - frame_done=1 for that one clk.
  - frame_cnt increments modulo 256.
  - en is sampled only here. If en=0, go to IDLE and drive idle flags (valid=0, syncs high). If en=1, continue with (0,0) in RUN.
- Mid-frame deassertion of en is ignored; the current frame always completes. frame_done and the frame_cnt increment occur on the final wrap even when entering IDLE.
- No frame_done pulse on the IDLE->RUN transition.
- Reset mid-frame: all state returns immediately to the reset values; after release, restart follows the IDLE rules.
- Latency: downstream sees the first visible pixel (0,0) in the same clk as the pix_tick that leaves IDLE.

Test Plan:
- Reset hold then release with en=1, CLK_DIV=4 -> pix_tick pulses at clks 3, 7, 11...; at the first tick h_cnt=0, v_cnt=0, valid=1, hsync=1; h_cnt=1 after the next tick.
- Run one full line -> valid falls when h_cnt=640; hsync=0 for h_cnt 656..751 (96 ticks); h_cnt wraps 799->0 and v_cnt increments 0->1 on the same tick.
- Run a full frame -> vsync=0 only for v_cnt 490..491 (1600 ticks); valid=0 for all v_cnt>=480; exactly one frame_done pulse at the 799/524->0/0 wrap; frame_cnt=1.
- Drop en at v_cnt=100 -> counting continues to the wrap; frame_done pulses; then valid=0, h_cnt=v_cnt=0, hsync=vsync=1 held; re-raise en -> restart at (0,0) on the next tick with no extra frame_done.
- Assert rst_n=0 at h_cnt=700, v_cnt=300 (hsync low region) -> all outputs take reset values immediately, asynchronous to clk; hsync=1.
- Run 256 frames -> frame_cnt wraps 255->0 and frame_done pulse count equals 256.
